seq_div_unit: RTL and testbench



---
 rtl/seq_div_unit.sv | 118 +++++++++++
 tb/tb_seq_div_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seq_div_unit.sv
// Multi-cycle restoring divider (DIV/DIVU): quotient on Lo, remainder on Hi, validIn/validOut handshake.
// Optional SEQ_DIV_ZERO_FAST_EN: a zero divisor skips CALC and goes straight to FIX.
module seq_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             validIn,
  input  logic             sign,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             validOut,
  output logic             busy,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] dvd, dvs, rem;
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r, dz;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] rem_nxt;
  logic             dz_in;

  always_comb begin
    mag_a   = (sign && SrcA[WIDTH-1]) ? -SrcA : SrcA;
    mag_b   = (sign && SrcB[WIDTH-1]) ? -SrcB : SrcB;
    dz_in   = (SrcB == '0);
    // One extra bit so a remainder with its MSB set still compares correctly.
    rem_sh  = {rem, dvd[WIDTH-1]};
    ge      = (rem_sh >= {1'b0, dvs});
    rem_nxt = ge ? (rem_sh[WIDTH-1:0] - dvs) : rem_sh[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (validIn) begin
`ifdef SEQ_DIV_ZERO_FAST_EN
        state_nxt = dz_in ? FIX : CALC;
`else
        state_nxt = CALC;
`endif
      end
      CALC: if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (!validIn) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        IDLE: if (validIn) begin
          dvd   <= mag_a;
          dvs   <= mag_b;
          rem   <= '0;
          cnt   <= CNT_INIT;
          neg_q <= sign & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
          neg_r <= sign & SrcA[WIDTH-1];
          dz    <= dz_in;
`ifdef SEQ_DIV_ZERO_FAST_EN
          // Preload what WIDTH iterations against a zero divisor would leave behind.
          if (dz_in) begin
            dvd <= '1;
            rem <= mag_a;
          end
`endif
        end
        CALC: begin
          rem <= rem_nxt;
          dvd <= {dvd[WIDTH-2:0], ge};
          if (cnt != '0) cnt <= cnt - CNT_ONE;
        end
        FIX: begin
          lo_q <= neg_q ? -dvd : dvd;
          hi_q <= neg_r ? -rem : rem;
        end
        default: ;
      endcase
    end
  end

  assign validOut    = (state == DONE);
  assign busy        = (state == CALC) || (state == FIX);
  assign div_by_zero = (state == DONE) && dz;
  assign Hi          = hi_q;
  assign Lo          = lo_q;

endmodule

// File: tb/tb_seq_div_unit.sv
// Directed self-checking bench for seq_div_unit (WIDTH=32), honours SEQ_DIV_ZERO_FAST_EN.
module tb_seq_div_unit;

  logic        clk = 1'b0;
  logic        reset, validIn, sign;
  logic [31:0] SrcA, SrcB;
  logic        validOut, busy, div_by_zero;
  logic [31:0] Hi, Lo;

  int errors = 0;
  int checks = 0;
  int lat, bcnt;

`ifdef SEQ_DIV_ZERO_FAST_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = 33;
`endif

  seq_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .validIn(validIn), .sign(sign),
    .SrcA(SrcA), .SrcB(SrcB),
    .validOut(validOut), .busy(busy), .div_by_zero(div_by_zero),
    .Hi(Hi), .Lo(Lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue a request, scramble the inputs after capture, and wait (bounded) for validOut.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int l, output int bc);
    @(negedge clk);
    validIn = 1'b1; sign = s; SrcA = a; SrcB = b;
    @(posedge clk); #1;
    l = 0; bc = 0;
    SrcA = ~a; SrcB = b + 32'd3; sign = ~s;
    while (!validOut && l < 80) begin
      if (busy) bc++;
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic release_req();
    @(negedge clk);
    validIn = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; validIn = 1'b0; sign = 1'b0; SrcA = '0; SrcB = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_validOut", 32'(validOut), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dz", 32'(div_by_zero), 32'd0);
    chk("rst_hi", Hi, 32'd0);
    chk("rst_lo", Lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // DIVU 100/7
    run_op(1'b0, 32'd100, 32'd7, lat, bcnt);
    chk("t1_latency", 32'(lat), 32'd33);
    chk("t1_busy_cycles", 32'(bcnt), 32'd33);
    chk("t1_lo", Lo, 32'd14);
    chk("t1_hi", Hi, 32'd2);
    chk("t1_dz", 32'(div_by_zero), 32'd0);
    release_req();
    chk("t1_idle_validOut", 32'(validOut), 32'd0);
    chk("t1_lo_kept", Lo, 32'd14);

    // DIV -7/2 and 7/-2
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
    chk("t2a_latency", 32'(lat), 32'd33);
    chk("t2a_lo", Lo, 32'hFFFF_FFFD);
    chk("t2a_hi", Hi, 32'hFFFF_FFFF);
    release_req();
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, lat, bcnt);
    chk("t2b_lo", Lo, 32'hFFFF_FFFD);
    chk("t2b_hi", Hi, 32'd1);
    release_req();

    // Signed overflow
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
    chk("t3_lo", Lo, 32'h8000_0000);
    chk("t3_hi", Hi, 32'd0);
    chk("t3_dz", 32'(div_by_zero), 32'd0);
    release_req();

    // DIVU by zero
    run_op(1'b0, 32'h1234_5678, 32'd0, lat, bcnt);
    chk("t4_latency", 32'(lat), 32'(DZ_LAT));
    chk("t4_busy_cycles", 32'(bcnt), 32'(DZ_LAT));
    chk("t4_lo", Lo, 32'hFFFF_FFFF);
    chk("t4_hi", Hi, 32'h1234_5678);
    chk("t4_dz", 32'(div_by_zero), 32'd1);
    release_req();
    chk("t4_dz_cleared", 32'(div_by_zero), 32'd0);

    // Signed divide by zero: -5/0 gives Lo=-(all ones)=1, Hi=-5
    run_op(1'b1, 32'hFFFF_FFFB, 32'd0, lat, bcnt);
    chk("t4s_latency", 32'(lat), 32'(DZ_LAT));
    chk("t4s_lo", Lo, 32'd1);
    chk("t4s_hi", Hi, 32'hFFFF_FFFB);
    release_req();

    // Held validIn in DONE, then drop, then 50/5
    run_op(1'b0, 32'd1000, 32'd3, lat, bcnt);
    chk("t5_first_lo", Lo, 32'd333);
    chk("t5_first_hi", Hi, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t5_hold_validOut", 32'(validOut), 32'd1);
      chk("t5_hold_busy", 32'(busy), 32'd0);
    end
    chk("t5_hold_lo", Lo, 32'd333);
    release_req();
    chk("t5_drop_validOut", 32'(validOut), 32'd0);
    chk("t5_drop_busy", 32'(busy), 32'd0);
    run_op(1'b0, 32'd50, 32'd5, lat, bcnt);
    chk("t5_latency", 32'(lat), 32'd33);
    chk("t5_lo", Lo, 32'd10);
    chk("t5_hi", Hi, 32'd0);
    release_req();

    // Reset at E+10 aborts the operation
    @(negedge clk);
    validIn = 1'b1; sign = 1'b0; SrcA = 32'd1000; SrcB = 32'd3;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; validIn = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst_validOut", 32'(validOut), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_hi", Hi, 32'd0);
    chk("t6_rst_lo", Lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("t6_idle_validOut", 32'(validOut), 32'd0);
    run_op(1'b0, 32'd144, 32'd12, lat, bcnt);
    chk("t6_latency", 32'(lat), 32'd33);
    chk("t6_lo", Lo, 32'd12);
    chk("t6_hi", Hi, 32'd0);
    release_req();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
